// File: rtl/phase_tp_timer.sv
// Phase/timepulse master timer: turns rising edges of the asynchronous CLOCK input into
// one-hot phase strobes, CT and a one-hot timepulse ring, with monitor stop/step and restart.
module phase_tp_timer #(
  parameter int unsigned NUM_PHASES = 4,
  parameter int unsigned NUM_TP     = 12
) (
  input  logic                  SIM_CLK,
  input  logic                  SIM_RST,
  input  logic                  CLOCK,
  input  logic                  RESTART,
  input  logic                  MSTP,
  input  logic                  STEP,
  output logic [NUM_PHASES-1:0] PHS,
  output logic                  CT,
  output logic [NUM_TP-1:0]     TP,
  output logic                  MCT_END
);

  localparam int unsigned PW = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1;
  localparam int unsigned TW = (NUM_TP > 2) ? $clog2(NUM_TP) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(NUM_PHASES - 1);
  localparam logic [PW-1:0] PH_HALF = PW'(NUM_PHASES / 2);
  localparam logic [TW-1:0] TP_LAST = TW'(NUM_TP - 1);

  logic [2:0]            sync_q, sync_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [TW-1:0]         tp_q, tp_d;
  logic                  running_q, running_d;
  logic                  restart_pend_q, restart_pend_d;
  logic                  step_pend_q, step_pend_d;
  logic [NUM_PHASES-1:0] phs_q, phs_d;
  logic [NUM_TP-1:0]     tp_oh_q, tp_oh_d;
  logic                  ct_q, ct_d;
  logic                  mct_end_q, mct_end_d;

  logic adv_c;
  logic restart_now_c;
  logic step_set_c;

  assign adv_c         = sync_q[1] & ~sync_q[2];
  assign restart_now_c = restart_pend_q | RESTART;
  // A restart in the same cycle swallows the step request.
  assign step_set_c    = STEP & ~RESTART;

  // State register
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      sync_q         <= '0;
      phase_q        <= PH_LAST;
      tp_q           <= TP_LAST;
      running_q      <= 1'b0;
      restart_pend_q <= 1'b0;
      step_pend_q    <= 1'b0;
      phs_q          <= '0;
      tp_oh_q        <= '0;
      ct_q           <= 1'b0;
      mct_end_q      <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      phase_q        <= phase_d;
      tp_q           <= tp_d;
      running_q      <= running_d;
      restart_pend_q <= restart_pend_d;
      step_pend_q    <= step_pend_d;
      phs_q          <= phs_d;
      tp_oh_q        <= tp_oh_d;
      ct_q           <= ct_d;
      mct_end_q      <= mct_end_d;
    end
  end

  // Next-state: phase/timepulse sequencing on each detected CLOCK rising edge
  always_comb begin
    sync_d         = {sync_q[1:0], CLOCK};
    phase_d        = phase_q;
    tp_d           = tp_q;
    running_d      = running_q;
    restart_pend_d = restart_now_c;
    step_pend_d    = step_pend_q | step_set_c;
    mct_end_d      = 1'b0;
    if (adv_c) begin
      if (!running_q || restart_now_c) begin
        running_d      = 1'b1;
        phase_d        = '0;
        tp_d           = '0;
        restart_pend_d = 1'b0;
        step_pend_d    = 1'b0;
      end else if (phase_q != PH_LAST) begin
        phase_d = phase_q + PW'(1);
      end else begin
        phase_d = '0;
        if (tp_q != TP_LAST) begin
          tp_d = tp_q + TW'(1);
        end else if (!MSTP || step_pend_q) begin
          // MCT wrap consumes any pending step; a step arriving now is kept.
          tp_d        = '0;
          mct_end_d   = 1'b1;
          step_pend_d = step_set_c;
        end
      end
    end
  end

  // Output decode from next state so every strobe leaves a flop
  always_comb begin
    phs_d   = '0;
    tp_oh_d = '0;
    ct_d    = 1'b0;
    if (running_d) begin
      phs_d   = NUM_PHASES'(1) << phase_d;
      tp_oh_d = NUM_TP'(1) << tp_d;
      ct_d    = (phase_d < PH_HALF);
    end
  end

  assign PHS     = phs_q;
  assign TP      = tp_oh_q;
  assign CT      = ct_q;
  assign MCT_END = mct_end_q;

endmodule

// File: tb/tb_phase_tp_timer.sv
// Bench for phase_tp_timer: default and 2-phase/3-TP instances share stimulus and are
// checked every cycle against an integer event model, plus directed literal checks.
module tb_phase_tp_timer;

  logic SIM_CLK, SIM_RST, CLOCK, RESTART, MSTP, STEP;
  logic [3:0]  phs0;
  logic [11:0] tp0;
  logic        ct0, mct0;
  logic [1:0]  phs1;
  logic [2:0]  tp1;
  logic        ct1, mct1;

  int n_cmp  = 0;
  int n_fail = 0;

  phase_tp_timer u_dut0 (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .CLOCK(CLOCK), .RESTART(RESTART),
    .MSTP(MSTP), .STEP(STEP), .PHS(phs0), .CT(ct0), .TP(tp0), .MCT_END(mct0)
  );

  phase_tp_timer #(.NUM_PHASES(2), .NUM_TP(3)) u_dut1 (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .CLOCK(CLOCK), .RESTART(RESTART),
    .MSTP(MSTP), .STEP(STEP), .PHS(phs1), .CT(ct1), .TP(tp1), .MCT_END(mct1)
  );

  initial SIM_CLK = 1'b0;
  always #5 SIM_CLK = ~SIM_CLK;

  // Behavioural model: integer phase/timepulse counters per instance
  int np [2] = '{4, 2};
  int nt [2] = '{12, 3};
  bit m_run [2];
  int m_ph  [2];
  int m_tp  [2];
  bit m_rp  [2];
  bit m_sp  [2];
  bit m_mct [2];
  bit smp1, smp2, smp3;   // CLOCK as sampled 1, 2 and 3 edges ago
  int mct_cnt0 = 0;
  int mct_cnt1 = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_ph[i] = np[i] - 1; m_tp[i] = nt[i] - 1;
      m_rp[i] = 0; m_sp[i] = 0; m_mct[i] = 0;
    end
    smp1 = 0; smp2 = 0; smp3 = 0;
  endtask

  task automatic model_edge(input int i, input bit adv);
    bit consumed;
    consumed = 0;
    m_mct[i] = 0;
    if (adv && (!m_run[i] || m_rp[i] || RESTART)) begin
      m_run[i] = 1; m_ph[i] = 0; m_tp[i] = 0; m_rp[i] = 0; m_sp[i] = 0;
      return;
    end
    if (adv) begin
      m_ph[i] = (m_ph[i] + 1) % np[i];
      if (m_ph[i] == 0) begin
        if (m_tp[i] < nt[i] - 1) m_tp[i]++;
        else if (!MSTP || m_sp[i]) begin
          m_tp[i] = 0; m_mct[i] = 1; consumed = 1;
        end
      end
    end
    m_rp[i] = m_rp[i] | RESTART;
    m_sp[i] = (m_sp[i] & !consumed) | (STEP & !RESTART);
  endtask

  always @(posedge SIM_CLK) begin
    if (!SIM_RST) model_reset();
    else begin
      for (int i = 0; i < 2; i++) model_edge(i, smp2 && !smp3);
      smp3 = smp2; smp2 = smp1; smp1 = CLOCK;
    end
  end

  function automatic int exp_oh(input int i, input bit is_tp);
    if (!m_run[i]) return 0;
    return 1 << (is_tp ? m_tp[i] : m_ph[i]);
  endfunction

  // Per-cycle compare of both instances against the model
  always @(negedge SIM_CLK) begin
    check("phs0", 32'(phs0), exp_oh(0, 0));
    check("tp0",  32'(tp0),  exp_oh(0, 1));
    check("ct0",  32'(ct0),  32'(m_run[0] && m_ph[0] < 2));
    check("mct0", 32'(mct0), 32'(m_mct[0]));
    check("phs1", 32'(phs1), exp_oh(1, 0));
    check("tp1",  32'(tp1),  exp_oh(1, 1));
    check("ct1",  32'(ct1),  32'(m_run[1] && m_ph[1] < 1));
    check("mct1", 32'(mct1), 32'(m_mct[1]));
    mct_cnt0 += int'(mct0);
    mct_cnt1 += int'(mct1);
  end

  task automatic clocks(input int n, input int hi, input int lo);
    repeat (n) begin
      CLOCK = 1'b1;
      repeat (hi) @(negedge SIM_CLK);
      CLOCK = 1'b0;
      repeat (lo) @(negedge SIM_CLK);
    end
  endtask

  task automatic pulse(input bit rs, input bit st);
    RESTART = rs; STEP = st;
    @(negedge SIM_CLK);
    RESTART = 1'b0; STEP = 1'b0;
  endtask

  task automatic run_to(input logic [3:0] ph, input logic [11:0] tp, input string name);
    int budget;
    budget = 200;
    while (!(phs0 == ph && tp0 == tp) && budget > 0) begin
      clocks(1, 2, 2);
      budget--;
    end
    if (budget == 0) check(name, 32'(tp0), 32'(tp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, ccnt;
    SIM_RST = 1'b0; CLOCK = 1'b0; RESTART = 1'b0; MSTP = 1'b0; STEP = 1'b0;
    model_reset();
    repeat (3) @(negedge SIM_CLK);
    check("rst_phs", 32'(phs0), 0);
    check("rst_tp",  32'(tp0),  0);
    check("rst_ct",  32'(ct0),  0);
    #2 SIM_RST = 1'b1;
    @(negedge SIM_CLK);

    // Latency: first high sample at edge k, outputs change at edge k+2
    CLOCK = 1'b1;
    @(negedge SIM_CLK); check("lat_k",  32'(phs0), 0);
    @(negedge SIM_CLK); check("lat_k1", 32'(tp0),  0);
    @(negedge SIM_CLK);
    check("lat_k2_phs", 32'(phs0), 32'h1);
    check("lat_k2_tp",  32'(tp0),  32'h1);
    check("lat_k2_ct",  32'(ct0),  1);
    CLOCK = 1'b0;
    repeat (4) @(negedge SIM_CLK);

    // Free run, CLOCK period 8: two full MCTs
    c0 = mct_cnt0; c1 = mct_cnt1;
    clocks(96, 4, 4);
    check("run_mct0", mct_cnt0 - c0, 2);
    check("run_mct1", mct_cnt1 - c1, 16);
    check("run_phs", 32'(phs0), 32'h1);
    check("run_tp",  32'(tp0),  32'h1);

    // Monitor stop, then a coalesced triple step releases one MCT
    MSTP = 1'b1;
    c0 = mct_cnt0;
    clocks(100, 2, 2);
    check("hold_mct", mct_cnt0 - c0, 0);
    check("hold_tp",  32'(tp0), 32'h800);
    pulse(1'b0, 1'b1); pulse(1'b0, 1'b1); pulse(1'b0, 1'b1);
    c0 = mct_cnt0;
    clocks(60, 2, 2);
    check("step_mct", mct_cnt0 - c0, 1);
    check("step_tp",  32'(tp0), 32'h800);

    // Restart mid-MCT, then restart+step together under hold
    MSTP = 1'b0;
    run_to(4'b0100, 12'h040, "reach_tp6");
    c0 = mct_cnt0;
    pulse(1'b1, 1'b0);
    clocks(1, 2, 2);
    check("rs_phs", 32'(phs0), 32'h1);
    check("rs_tp",  32'(tp0),  32'h1);
    check("rs_mct", mct_cnt0 - c0, 0);
    MSTP = 1'b1;
    pulse(1'b1, 1'b1);
    c0 = mct_cnt0;
    clocks(60, 2, 2);
    check("rsst_mct", mct_cnt0 - c0, 0);
    check("rsst_tp",  32'(tp0), 32'h800);

    // Asynchronous reset mid-run
    MSTP = 1'b0;
    pulse(1'b1, 1'b0);
    run_to(4'b0001, 12'h020, "reach_tp5");
    #2 SIM_RST = 1'b0;
    model_reset();
    #1;
    check("arst_phs", 32'(phs0), 0);
    check("arst_tp",  32'(tp0),  0);
    check("arst_tp1", 32'(tp1),  0);
    repeat (3) @(negedge SIM_CLK);
    #2 SIM_RST = 1'b1;
    @(negedge SIM_CLK);
    clocks(1, 2, 2);
    check("arst_rel_phs", 32'(phs0), 32'h1);
    check("arst_rel_tp",  32'(tp0),  32'h1);

    // Randomized traffic against the model
    ccnt = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge SIM_CLK);
      ccnt--;
      if (ccnt == 0) begin
        CLOCK = ~CLOCK;
        ccnt = $urandom_range(1, 5);
      end
      if ($urandom_range(0, 199) == 0) MSTP = ~MSTP;
      STEP    = ($urandom_range(0, 29) == 0);
      RESTART = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 999) == 0) begin
        #2 SIM_RST = 1'b0;
        model_reset();
        repeat (2) @(negedge SIM_CLK);
        #2 SIM_RST = 1'b1;
      end
    end
    RESTART = 1'b0; STEP = 1'b0;
    @(negedge SIM_CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
